// File: rtl/serial_image_loader.sv
// Streams N_REGIONS memory images into a target core over a serial {data,addr} frame link,
// with a done_in handshake after each region, then holds the core in run mode.
module serial_image_loader #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int N_REGIONS   = 2,
   parameter int CLK_DIV     = 1,
   parameter int ACK_TIMEOUT = 255,
   localparam int MODE_W     = $clog2(N_REGIONS + 2),
   localparam int REG_W      = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 drive,
   input  logic [N_REGIONS-1:0] region_en,
   input  logic                 done_in,
   output logic                 rd_en,
   output logic [REG_W-1:0]     rd_region,
   output logic [ADDR_W-1:0]    rd_addr,
   input  logic [DATA_W-1:0]    rd_data,
   output logic                 sclk_out,
   output logic                 mosi_out,
   output logic [MODE_W-1:0]    mode_out,
   output logic                 busy,
   output logic                 error
);

   localparam int FRAME_W = ADDR_W + DATA_W;
   localparam int BIT_W   = $clog2(FRAME_W + 1);
   localparam int CNT_W   = $clog2(2 * CLK_DIV + 1);
   localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);

   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [MODE_W-1:0] MODE_RUN  = MODE_W'(N_REGIONS + 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      GAP,
      WAIT_ACK,
      RUN,
      ERR
   } state_t;

   state_t               state_q, state_d;
   logic                 drive_prev_q, drive_prev_d;
   logic [N_REGIONS-1:0] pend_q, pend_d;
   logic [REG_W-1:0]     region_q, region_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [FRAME_W-1:0]   shift_q, shift_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 half_q, half_d;
   logic [TO_W-1:0]      tcnt_q, tcnt_d;

   logic                 rd_en_q, rd_en_d;
   logic [REG_W-1:0]     rd_region_q, rd_region_d;
   logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
   logic                 sclk_q, sclk_d;
   logic                 mosi_q, mosi_d;
   logic [MODE_W-1:0]    mode_q, mode_d;
   logic                 busy_q, busy_d;
   logic                 error_q, error_d;

   logic [N_REGIONS-1:0] pend_left;
   logic [REG_W:0]       start_pick;
   logic [REG_W:0]       next_pick;
   logic                 loading;

   // Returns {found, index} of the lowest set bit, so regions always load in index order.
   function automatic logic [REG_W:0] lowest_set(input logic [N_REGIONS-1:0] mask);
      logic [REG_W:0] res;
      res = '0;
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            res = {1'b1, REG_W'(i)};
         end
      end
      return res;
   endfunction

   assign pend_left  = pend_q & ~(N_REGIONS'(1) << region_q);
   assign start_pick = lowest_set(region_en);
   assign next_pick  = lowest_set(pend_left);

   always_comb begin
      state_d      = state_q;
      drive_prev_d = drive;
      pend_d       = pend_q;
      region_d     = region_q;
      addr_d       = addr_q;
      shift_d      = shift_q;
      bit_d        = bit_q;
      cnt_d        = cnt_q;
      half_d       = half_q;
      tcnt_d       = tcnt_q;

      if (state_q != IDLE && !drive) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (drive && !drive_prev_q) begin
                  pend_d = region_en;
                  if (start_pick[REG_W]) begin
                     state_d  = FETCH;
                     region_d = start_pick[REG_W-1:0];
                     addr_d   = '0;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            FETCH: begin
               state_d = LOAD;
            end
            LOAD: begin
               state_d = SHIFT;
               shift_d = {rd_data, addr_q};
               bit_d   = '0;
               cnt_d   = '0;
               half_d  = 1'b0;
            end
            SHIFT: begin
               // Each bit is CLK_DIV cycles low then CLK_DIV cycles high; advance after the high half.
               if (cnt_q == HALF_LAST) begin
                  cnt_d = '0;
                  if (!half_q) begin
                     half_d = 1'b1;
                  end else begin
                     half_d = 1'b0;
                     if (bit_q == BIT_LAST) begin
                        state_d = GAP;
                     end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d = '0;
                  if (addr_q == ADDR_LAST) begin
                     state_d = WAIT_ACK;
                     tcnt_d  = '0;
                  end else begin
                     state_d = FETCH;
                     addr_d  = addr_q + ADDR_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WAIT_ACK: begin
               if (done_in) begin
                  pend_d = pend_left;
                  if (next_pick[REG_W]) begin
                     state_d  = FETCH;
                     region_d = next_pick[REG_W-1:0];
                     addr_d   = '0;
                  end else begin
                     state_d = RUN;
                  end
               end else if (tcnt_q == TO_LAST) begin
                  state_d = ERR;
               end else begin
                  tcnt_d = tcnt_q + TO_W'(1);
               end
            end
            RUN: begin
               state_d = RUN;
            end
            ERR: begin
               state_d = ERR;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // Outputs are a registered decode of the next state, so they line up with state_q.
      loading     = (state_d == FETCH) || (state_d == LOAD) || (state_d == SHIFT);
      rd_en_d     = (state_d == FETCH);
      rd_region_d = rd_en_d ? region_d : '0;
      rd_addr_d   = rd_en_d ? addr_d : '0;
      sclk_d      = (state_d == SHIFT) && half_d;
      mosi_d      = (state_d == SHIFT) && shift_d[0];
      busy_d      = (state_d != IDLE);
      error_d     = (state_d == ERR);
      if (loading) begin
         mode_d = MODE_W'(region_d) + MODE_W'(1);
      end else if (state_d == RUN) begin
         mode_d = MODE_RUN;
      end else begin
         mode_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         drive_prev_q <= 1'b0;
         pend_q       <= '0;
         region_q     <= '0;
         addr_q       <= '0;
         shift_q      <= '0;
         bit_q        <= '0;
         cnt_q        <= '0;
         half_q       <= 1'b0;
         tcnt_q       <= '0;
         rd_en_q      <= 1'b0;
         rd_region_q  <= '0;
         rd_addr_q    <= '0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         mode_q       <= '0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         drive_prev_q <= drive_prev_d;
         pend_q       <= pend_d;
         region_q     <= region_d;
         addr_q       <= addr_d;
         shift_q      <= shift_d;
         bit_q        <= bit_d;
         cnt_q        <= cnt_d;
         half_q       <= half_d;
         tcnt_q       <= tcnt_d;
         rd_en_q      <= rd_en_d;
         rd_region_q  <= rd_region_d;
         rd_addr_q    <= rd_addr_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         mode_q       <= mode_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
      end
   end

   assign rd_en     = rd_en_q;
   assign rd_region = rd_region_q;
   assign rd_addr   = rd_addr_q;
   assign sclk_out  = sclk_q;
   assign mosi_out  = mosi_q;
   assign mode_out  = mode_q;
   assign busy      = busy_q;
   assign error     = error_q;

endmodule

// File: tb/tb_serial_image_loader.sv
// Directed bench for serial_image_loader: default, CLK_DIV=3 and three-region instances
// driven from one initial block, with image memories answering one cycle after rd_en.
module tb_serial_image_loader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   // Default instance
   logic       drive = 1'b0;
   logic [1:0] region_en = 2'b00;
   logic       done_in = 1'b0;
   logic       rd_en;
   logic       rd_region;
   logic [3:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic       sclk;
   logic       mosi;
   logic [1:0] mode;
   logic       busy;
   logic       error;

   // CLK_DIV=3 instance
   logic       d3_drive = 1'b0;
   logic [1:0] d3_region_en = 2'b00;
   logic       d3_done = 1'b0;
   logic       d3_rd_en;
   logic       d3_rd_region;
   logic [3:0] d3_rd_addr;
   logic [7:0] d3_rd_data = 8'h00;
   logic       d3_sclk;
   logic       d3_mosi;
   logic [1:0] d3_mode;
   logic       d3_busy;
   logic       d3_error;

   // Three-region, 4-word instance
   logic       r3_drive = 1'b0;
   logic [2:0] r3_region_en = 3'b000;
   logic       r3_done = 1'b0;
   logic       r3_rd_en;
   logic [1:0] r3_rd_region;
   logic [1:0] r3_rd_addr;
   logic [7:0] r3_rd_data = 8'h00;
   logic       r3_sclk;
   logic       r3_mosi;
   logic [2:0] r3_mode;
   logic       r3_busy;
   logic       r3_error;

   serial_image_loader dut (
      .clk(clk), .rst_n(rst_n), .drive(drive), .region_en(region_en), .done_in(done_in),
      .rd_en(rd_en), .rd_region(rd_region), .rd_addr(rd_addr), .rd_data(rd_data),
      .sclk_out(sclk), .mosi_out(mosi), .mode_out(mode), .busy(busy), .error(error)
   );

   serial_image_loader #(.CLK_DIV(3)) dut_div3 (
      .clk(clk), .rst_n(rst_n), .drive(d3_drive), .region_en(d3_region_en), .done_in(d3_done),
      .rd_en(d3_rd_en), .rd_region(d3_rd_region), .rd_addr(d3_rd_addr), .rd_data(d3_rd_data),
      .sclk_out(d3_sclk), .mosi_out(d3_mosi), .mode_out(d3_mode), .busy(d3_busy), .error(d3_error)
   );

   serial_image_loader #(.ADDR_W(2), .N_REGIONS(3)) dut_r3 (
      .clk(clk), .rst_n(rst_n), .drive(r3_drive), .region_en(r3_region_en), .done_in(r3_done),
      .rd_en(r3_rd_en), .rd_region(r3_rd_region), .rd_addr(r3_rd_addr), .rd_data(r3_rd_data),
      .sclk_out(r3_sclk), .mosi_out(r3_mosi), .mode_out(r3_mode), .busy(r3_busy), .error(r3_error)
   );

   function automatic logic [7:0] img(input int r, input int a);
      return 8'hA5 ^ 8'((r << 4) | (a ^ 3));
   endfunction

   function automatic logic [7:0] img3(input int r, input int a);
      return 8'h3C ^ 8'((r << 5) | a);
   endfunction

   // Image memories: read data valid one cycle after the strobe
   always @(posedge clk) begin
      if (rd_en) rd_data <= img(int'(rd_region), int'(rd_addr));
      if (d3_rd_en) d3_rd_data <= img(int'(d3_rd_region), int'(d3_rd_addr));
      if (r3_rd_en) r3_rd_data <= img3(int'(r3_rd_region), int'(r3_rd_addr));
   end

   // Decodes frames of the default instance until run mode, acking 3 cycles into WAIT_ACK
   task automatic collect_main(input int budget, output int n1, output int n2, output int bad,
                               output int timed_out, output logic [11:0] frame3);
      int bits;
      int ack_cnt;
      int r;
      int aexp[2];
      logic [11:0] sh;
      logic [1:0] pm;
      logic ps;
      n1 = 0; n2 = 0; bad = 0; bits = 0; ack_cnt = 0; timed_out = 1;
      aexp[0] = 0; aexp[1] = 0;
      sh = '0; frame3 = '0; pm = mode; ps = sclk;
      for (int cyc = 0; cyc < budget && timed_out == 1; cyc++) begin
         @(negedge clk);
         if (done_in) done_in = 1'b0;
         if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) done_in = 1'b1;
         end
         if (sclk && !ps) begin
            sh = {mosi, sh[11:1]};
            bits++;
         end
         if (mode == 2'd0 && (pm == 2'd1 || pm == 2'd2)) begin
            r = int'(pm) - 1;
            if (bits != 12 || sh != {img(r, aexp[r]), 4'(aexp[r])}) bad++;
            if (r == 0 && aexp[r] == 3) frame3 = sh;
            if (r == 0) n1++;
            else n2++;
            aexp[r]++;
            if (aexp[r] == 16) ack_cnt = 5;
            bits = 0;
         end
         ps = sclk;
         pm = mode;
         if (mode == 2'd3) timed_out = 0;
      end
   endtask

   task automatic test_reset;
      #2;
      n_checks++;
      if ({sclk, mosi, mode, rd_en, busy, error} !== 7'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_outputs: got %b, want 0000000", {sclk, mosi, mode, rd_en, busy, error});
      end
      n_checks++;
      if ({rd_region, rd_addr} !== 5'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_rd_port: got %h, want 00", {rd_region, rd_addr});
      end
      n_checks++;
      if ({d3_busy, r3_busy, r3_mode} !== 5'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_other: got %b, want 00000", {d3_busy, r3_busy, r3_mode});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || mode !== 2'd0) begin
         n_errors++;
         $display("[TB] FAIL idle_after_reset: got busy=%b mode=%0d, want 0 0", busy, mode);
      end
   endtask

   task automatic test_full_load;
      int n1, n2, bad, to;
      logic [11:0] f3;
      @(negedge clk);
      region_en = 2'b11;
      drive = 1'b1;
      collect_main(3000, n1, n2, bad, to, f3);
      n_checks++;
      if (to !== 0) begin n_errors++; $display("[TB] FAIL t1_reach_run: timed out, want mode 3"); end
      n_checks++;
      if (n1 !== 16) begin n_errors++; $display("[TB] FAIL t1_frames_r0: got %0d, want 16", n1); end
      n_checks++;
      if (n2 !== 16) begin n_errors++; $display("[TB] FAIL t1_frames_r1: got %0d, want 16", n2); end
      n_checks++;
      if (bad !== 0) begin n_errors++; $display("[TB] FAIL t1_frame_content: got %0d bad, want 0", bad); end
      n_checks++;
      if (f3 !== 12'hA53) begin n_errors++; $display("[TB] FAIL t1_frame_a5_3: got %h, want a53", f3); end
      n_checks++;
      if (busy !== 1'b1 || error !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL t1_run_flags: got busy=%b error=%b, want 1 0", busy, error);
      end
      done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mode !== 2'd3) begin n_errors++; $display("[TB] FAIL t1_run_hold: got mode %0d, want 3", mode); end
      drive = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mode !== 2'd0 || busy !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL t1_run_exit: got mode=%0d busy=%b, want 0 0", mode, busy);
      end
   endtask

   task automatic test_region_skip;
      int n1, n2, bad, to;
      logic [11:0] f3;
      region_en = 2'b10;
      drive = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rd_en !== 1'b1 || rd_region !== 1'b1 || rd_addr !== 4'd0 || mode !== 2'd2) begin
         n_errors++;
         $display("[TB] FAIL t3_first_fetch: got en=%b reg=%0d addr=%0d mode=%0d, want 1 1 0 2",
                  rd_en, rd_region, rd_addr, mode);
      end
      collect_main(1500, n1, n2, bad, to, f3);
      n_checks++;
      if (to !== 0 || n1 !== 0 || n2 !== 16 || bad !== 0) begin
         n_errors++;
         $display("[TB] FAIL t3_skip_load: got to=%0d n1=%0d n2=%0d bad=%0d, want 0 0 16 0", to, n1, n2, bad);
      end
      drive = 1'b0;
      @(negedge clk);
      region_en = 2'b00;
      drive = 1'b1;
      @(negedge clk);
      n_checks++;
      if (mode !== 2'd3 || busy !== 1'b1 || rd_en !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL t3_none_run: got mode=%0d busy=%b rd_en=%b, want 3 1 0", mode, busy, rd_en);
      end
      drive = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ack_timeout;
      int falls;
      logic [1:0] pm;
      falls = 0;
      pm = 2'd0;
      region_en = 2'b01;
      drive = 1'b1;
      for (int cyc = 0; cyc < 1000 && falls < 16; cyc++) begin
         @(negedge clk);
         if (mode == 2'd0 && pm != 2'd0) falls++;
         pm = mode;
      end
      n_checks++;
      if (falls !== 16) begin n_errors++; $display("[TB] FAIL t4_frames: got %0d, want 16", falls); end
      repeat (256) @(negedge clk);
      n_checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL t4_before_timeout: got error=%b busy=%b, want 0 1", error, busy);
      end
      @(negedge clk);
      n_checks++;
      if (error !== 1'b1 || mode !== 2'd0 || sclk !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL t4_timeout: got error=%b mode=%0d sclk=%b, want 1 0 0", error, mode, sclk);
      end
      done_in = 1'b1;
      repeat (5) @(negedge clk);
      done_in = 1'b0;
      n_checks++;
      if (error !== 1'b1) begin n_errors++; $display("[TB] FAIL t4_sticky: got %b, want 1", error); end
      drive = 1'b0;
      @(negedge clk);
      n_checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL t4_clear: got error=%b busy=%b, want 0 0", error, busy);
      end
   endtask

   task automatic test_abort;
      int falls;
      int found;
      logic [1:0] pm;
      falls = 0;
      found = 0;
      pm = 2'd0;
      region_en = 2'b11;
      drive = 1'b1;
      for (int cyc = 0; cyc < 500 && falls < 7; cyc++) begin
         @(negedge clk);
         if (mode == 2'd0 && pm != 2'd0) falls++;
         pm = mode;
      end
      for (int cyc = 0; cyc < 5 && found == 0; cyc++) begin
         @(negedge clk);
         if (rd_en) found = 1;
      end
      n_checks++;
      if (found !== 1 || rd_addr !== 4'd7 || rd_region !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL t5_fetch7: got found=%0d addr=%0d reg=%0d, want 1 7 0", found, rd_addr, rd_region);
      end
      repeat (6) @(negedge clk);
      n_checks++;
      if (mode !== 2'd1 || busy !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL t5_mid_shift: got mode=%0d busy=%b, want 1 1", mode, busy);
      end
      drive = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({sclk, mosi, mode, busy, rd_en} !== 6'b0) begin
         n_errors++;
         $display("[TB] FAIL t5_abort: got %b, want 000000", {sclk, mosi, mode, busy, rd_en});
      end
      drive = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rd_en !== 1'b1 || rd_addr !== 4'd0 || mode !== 2'd1) begin
         n_errors++;
         $display("[TB] FAIL t5_restart: got en=%b addr=%0d mode=%0d, want 1 0 1", rd_en, rd_addr, mode);
      end
      drive = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clk_div3;
      int found;
      int zeros;
      int next_fetch;
      logic exp_sclk;
      found = 0;
      zeros = 0;
      next_fetch = 0;
      d3_region_en = 2'b01;
      d3_drive = 1'b1;
      @(negedge clk);
      n_checks++;
      if (d3_rd_en !== 1'b1 || d3_mode !== 2'd1) begin
         n_errors++;
         $display("[TB] FAIL t2_fetch: got en=%b mode=%0d, want 1 1", d3_rd_en, d3_mode);
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         exp_sclk = (i >= 5 && i <= 7);
         n_checks++;
         if (d3_sclk !== exp_sclk) begin
            n_errors++;
            $display("[TB] FAIL t2_sclk_c%0d: got %b, want %b", i, d3_sclk, exp_sclk);
         end
      end
      for (int i = 9; i < 200 && found == 0; i++) begin
         @(negedge clk);
         if (d3_mode == 2'd0) zeros++;
         if (d3_rd_en) begin
            found = 1;
            next_fetch = i;
         end
      end
      n_checks++;
      if (next_fetch !== 80) begin n_errors++; $display("[TB] FAIL t2_period: got %0d, want 80", next_fetch); end
      n_checks++;
      if (zeros !== 6) begin n_errors++; $display("[TB] FAIL t2_gap: got %0d, want 6", zeros); end
      d3_drive = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_async_reset;
      int found;
      found = 0;
      region_en = 2'b11;
      drive = 1'b1;
      for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
         @(negedge clk);
         if (sclk) found = 1;
      end
      n_checks++;
      if (found !== 1) begin n_errors++; $display("[TB] FAIL t6_sclk_high: got none, want a rise"); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({sclk, mosi, mode, busy, rd_en} !== 6'b0) begin
         n_errors++;
         $display("[TB] FAIL t6_async_reset: got %b, want 000000", {sclk, mosi, mode, busy, rd_en});
      end
      drive = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || sclk !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL t6_after_reset: got busy=%b sclk=%b, want 0 0", busy, sclk);
      end
   endtask

   task automatic test_three_regions;
      int n[4];
      int aexp[3];
      int bits, ack_cnt, r, bad, reached;
      logic [9:0] sh;
      logic [2:0] pm;
      logic ps;
      for (int i = 0; i < 4; i++) n[i] = 0;
      for (int i = 0; i < 3; i++) aexp[i] = 0;
      bits = 0; ack_cnt = 0; bad = 0; reached = 0; sh = '0;
      @(negedge clk);
      r3_region_en = 3'b111;
      r3_drive = 1'b1;
      pm = r3_mode;
      ps = r3_sclk;
      for (int cyc = 0; cyc < 1500 && reached == 0; cyc++) begin
         @(negedge clk);
         if (r3_done) r3_done = 1'b0;
         if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) r3_done = 1'b1;
         end
         if (r3_sclk && !ps) begin
            sh = {r3_mosi, sh[9:1]};
            bits++;
         end
         if (r3_mode == 3'd0 && pm >= 3'd1 && pm <= 3'd3) begin
            r = int'(pm) - 1;
            if (bits != 10 || sh != {img3(r, aexp[r]), 2'(aexp[r])}) bad++;
            n[r + 1]++;
            aexp[r]++;
            if (aexp[r] == 4) ack_cnt = 2;
            bits = 0;
         end
         ps = r3_sclk;
         pm = r3_mode;
         if (r3_mode == 3'd4) reached = 1;
      end
      n_checks++;
      if (reached !== 1) begin n_errors++; $display("[TB] FAIL t6_r3_run: timed out, want mode 4"); end
      n_checks++;
      if (n[1] !== 4 || n[2] !== 4 || n[3] !== 4) begin
         n_errors++;
         $display("[TB] FAIL t6_r3_frames: got %0d %0d %0d, want 4 4 4", n[1], n[2], n[3]);
      end
      n_checks++;
      if (bad !== 0) begin n_errors++; $display("[TB] FAIL t6_r3_content: got %0d bad, want 0", bad); end
      r3_drive = 1'b0;
      @(negedge clk);
      n_checks++;
      if (r3_mode !== 3'd0 || r3_busy !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL t6_r3_exit: got mode=%0d busy=%b, want 0 0", r3_mode, r3_busy);
      end
   endtask

   initial begin
      $display("[TB] serial_image_loader directed tests");
      test_reset();
      test_full_load();
      test_region_skip();
      test_ack_timeout();
      test_abort();
      test_clk_div3();
      test_async_reset();
      test_three_regions();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
